// File: rtl/dot_pkg.sv
// Shared types and sizing helpers for the dot-product engine.
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Wide enough that max_len full-scale products cannot wrap.
    function automatic int acc_width(input int data_w, input int max_len);
        return 2 * data_w + $clog2(max_len);
    endfunction

endpackage

// File: rtl/mac_stage.sv
// Product register and accumulator. The product is captured one cycle and
// added into the accumulator the next, so the multiplier and adder never chain.
module mac_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  capture,
    input  logic                  add,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    logic [PROD_WIDTH-1:0] prod_q;
    logic [ACC_WIDTH-1:0]  acc_q;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else if (clear) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            if (capture) begin
                prod_q <= PROD_WIDTH'(a) * PROD_WIDTH'(b);
            end
            if (add) begin
                acc_q <= acc_q + ACC_WIDTH'(prod_q);
            end
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/dot_product_engine.sv
// Unsigned dot product of two operand streams with valid/ready on both sides.
// Build option: define DOT_SATURATE_EN to clamp result to all-ones on overflow.
module dot_product_engine
    import dot_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 16,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1),
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  busy
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);

    state_t                  state_q;
    state_t                  state_d;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    beat_cnt_q;
    logic [LEN_WIDTH-1:0]    len_clamped;
    logic                    add_pending_q;
    logic                    clear;
    logic                    capture;
    logic                    load_out;
    logic                    release_out;
    logic                    last_beat;
    logic [ACC_WIDTH-1:0]    acc;
    logic                    acc_ovf;
    logic [DATA_WIDTH-1:0]   result_d;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    overflow_q;

    assign len_clamped = (vec_len > MAX_LEN_L) ? MAX_LEN_L : vec_len;
    assign last_beat   = (beat_cnt_q == len_q - LEN_WIDTH'(1));

    mac_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .capture (capture),
        .add     (add_pending_q),
        .a       (a),
        .b       (b),
        .acc     (acc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        clear       = 1'b0;
        capture     = 1'b0;
        load_out    = 1'b0;
        release_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = (len_clamped == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    capture = 1'b1;
                    if (last_beat) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                // First HOLD cycle registers the final accumulator value.
                if (!out_valid_q) begin
                    load_out = 1'b1;
                end else if (out_ready) begin
                    release_out = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q         <= '0;
            beat_cnt_q    <= '0;
            add_pending_q <= 1'b0;
        end else begin
            add_pending_q <= capture;
            if (clear) begin
                len_q      <= len_clamped;
                beat_cnt_q <= '0;
            end else if (capture) begin
                beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    assign acc_ovf = |acc[ACC_WIDTH-1:DATA_WIDTH];

`ifdef DOT_SATURATE_EN
    assign result_d = acc_ovf ? {DATA_WIDTH{1'b1}} : acc[DATA_WIDTH-1:0];
`else
    assign result_d = acc[DATA_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            overflow_q  <= acc_ovf;
        end else if (release_out) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Scenario bench for dot_product_engine; expected results go through a queue.
module tb_dot_product_engine;

    localparam int DW = 8;
    localparam int LW = 5;

    typedef struct {
        logic [DW-1:0] res;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [LW-1:0] vec_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          overflow;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    dot_product_engine #(
        .DATA_WIDTH (DW),
        .MAX_LEN    (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int unsigned sum);
        exp_t e;
        e.ovf = (sum > 255);
`ifdef DOT_SATURATE_EN
        e.res = e.ovf ? 8'hFF : sum[7:0];
`else
        e.res = sum[7:0];
`endif
        return e;
    endfunction

    task automatic do_start(input logic [LW-1:0] len);
        @(negedge clk);
        start   = 1'b1;
        vec_len = len;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic feed(input logic [DW-1:0] av, input logic [DW-1:0] bv, output bit accepted);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        accepted = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit timed_out, output int cycles);
        cycles    = 0;
        timed_out = 1'b0;
        while (out_valid !== 1'b1) begin
            if (cycles >= 200) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, result, overflow, busy} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {in_ready, out_valid, result, overflow, busy});
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy got %b required 0", busy);
        end
    endtask

    task automatic test_sum();
        exp_t e;
        bit   to;
        bit   acc1, acc2, acc3;
        int   cyc;
        out_ready = 1'b1;
        sb.push_back(model(2*3 + 4*5 + 1*1));
        do_start(3);
        feed(8'd2, 8'd3, acc1);
        feed(8'd4, 8'd5, acc2);
        feed(8'd1, 8'd1, acc3);
        checks++;
        if ({acc1, acc2, acc3} !== 3'b111) begin
            errors++;
            $display("FAIL sum_accept: got %b required 111", {acc1, acc2, acc3});
        end
        wait_out(to, cyc);
        checks++;
        if (to !== 1'b0) begin
            errors++;
            $display("FAIL sum_timeout: out_valid never rose");
        end
        checks++;
        if (cyc + 3 !== 5) begin
            errors++;
            $display("FAIL sum_latency: got %0d cycles required 5", cyc + 3);
        end
        e = sb.pop_front();
        checks++;
        if (result !== e.res || overflow !== e.ovf) begin
            errors++;
            $display("FAIL sum_result: got %0d/%b required %0d/%b", result, overflow, e.res, e.ovf);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sum_release: out_valid/busy got %b%b required 00", out_valid, busy);
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        bit   to;
        bit   acc;
        int   cyc;
        out_ready = 1'b1;
        sb.push_back(model(16 * 16));
        do_start(1);
        feed(8'd16, 8'd16, acc);
        wait_out(to, cyc);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || result !== e.res || overflow !== e.ovf) begin
            errors++;
            $display("FAIL ovf_256: got %0d/%b timeout %b required %0d/%b", result, overflow, to, e.res, e.ovf);
        end
        @(negedge clk);
        sb.push_back(model(200));
        do_start(2);
        feed(8'd10, 8'd10, acc);
        feed(8'd10, 8'd10, acc);
        wait_out(to, cyc);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || result !== e.res || overflow !== e.ovf) begin
            errors++;
            $display("FAIL ovf_200: got %0d/%b timeout %b required %0d/%b", result, overflow, to, e.res, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   to;
        bit   acc;
        int   cyc;
        out_ready = 1'b0;
        sb.push_back(model(4 * 9));
        do_start(4);
        feed(8'd3, 8'd3, acc);
        feed(8'd3, 8'd3, acc);
        repeat (2) @(negedge clk);
        feed(8'd3, 8'd3, acc);
        feed(8'd3, 8'd3, acc);
        wait_out(to, cyc);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0) begin
            errors++;
            $display("FAIL bp_timeout: out_valid never rose");
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== e.res || overflow !== e.ovf) begin
                errors++;
                $display("FAIL bp_hold%0d: got %b/%0d/%b required 1/%0d/%b", i, out_valid, result, overflow, e.res, e.ovf);
            end
            start   = (i == 1);
            vec_len = 5'd2;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || result !== e.res) begin
            errors++;
            $display("FAIL bp_start_ignored: busy/valid/result got %b/%b/%0d required 1/1/%0d", busy, out_valid, result, e.res);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake_start: out_valid/busy got %b%b required 00", out_valid, busy);
        end
    endtask

    task automatic test_zero_len();
        exp_t e;
        bit   to;
        int   cyc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'd9;
        b         = 8'd9;
        sb.push_back(model(0));
        do_start(0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_in_ready: got %b required 0", in_ready);
        end
        wait_out(to, cyc);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || cyc !== 1) begin
            errors++;
            $display("FAIL zero_latency: got %0d cycles timeout %b required 1", cyc, to);
        end
        checks++;
        if (result !== e.res || overflow !== e.ovf || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_result: got %0d/%b ready %b required %0d/%b ready 0", result, overflow, in_ready, e.res, e.ovf);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   to;
        bit   acc;
        int   cyc;
        out_ready = 1'b1;
        do_start(4);
        feed(8'd5, 8'd5, acc);
        feed(8'd5, 8'd5, acc);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, result, overflow, busy} !== 12'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b required 0", {in_ready, out_valid, result, overflow, busy});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        sb.push_back(model(7 * 6));
        do_start(1);
        feed(8'd7, 8'd6, acc);
        wait_out(to, cyc);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || result !== e.res || overflow !== e.ovf) begin
            errors++;
            $display("FAIL midreset_rerun: got %0d/%b timeout %b required %0d/%b", result, overflow, to, e.res, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_len_clamp();
        exp_t e;
        bit   to;
        int   cyc;
        int   n_acc;
        out_ready = 1'b0;
        sb.push_back(model(16));
        do_start(5'd20);
        n_acc    = 0;
        in_valid = 1'b1;
        a        = 8'd1;
        b        = 8'd1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) n_acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (n_acc !== 16) begin
            errors++;
            $display("FAIL clamp_beats: got %0d required 16", n_acc);
        end
        wait_out(to, cyc);
        e = sb.pop_front();
        checks++;
        if (to !== 1'b0 || result !== e.res || overflow !== e.ovf) begin
            errors++;
            $display("FAIL clamp_result: got %0d/%b timeout %b required %0d/%b", result, overflow, to, e.res, e.ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        vec_len   = '0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        test_reset();
        test_sum();
        test_overflow();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_len_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
